afpm_mul_scheduler: RTL and testbench

AFPM_MUL_SCHEDULER -- requirements
Module: afpm_mul_scheduler

---
 rtl/afpm_sched_pkg.sv | 28 ++
 rtl/afpm_rr_arb2.sv | 21 ++
 rtl/afpm_mul_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_afpm_mul_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afpm_sched_pkg.sv
// -----------------------------------------------------------------------------
// afpm_sched_pkg
// Shared definitions for the FP16 multiplier scheduler:
//   - sched_state_t : scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   - FP16 field widths / exponent bias and the canonical quiet-NaN pattern
//   - NUM_REQ       : number of requesters sharing the multiplier
// -----------------------------------------------------------------------------
package afpm_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    localparam int FP16_W      = 16;
    localparam int FP16_SIGN_W = 1;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MAN_W  = 10;
    localparam int FP16_BIAS   = 15;

    // Quiet NaN returned when the datapath never answers.
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/afpm_rr_arb2.sv
// -----------------------------------------------------------------------------
// afpm_rr_arb2
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   valid   [1:0] : request vector, bit i = requester i
//   pointer       : preferred requester when both are valid
//   grant   [1:0] : one-hot grant, all-zero when nothing is valid
// -----------------------------------------------------------------------------
module afpm_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        // A requester wins when it is valid and either the other side is idle
        // or the pointer prefers it; the pointer never blocks a lone request.
        assign grant[gi] = valid[gi] & (~valid[1-gi] | (pointer == 1'(gi)));
    end

endmodule

// File: rtl/afpm_mul_scheduler.sv
// -----------------------------------------------------------------------------
// afpm_mul_scheduler
// Shares one FP16 multiplier datapath between two requesters, one operation
// in flight at a time, with round-robin arbitration.
//
// Optional feature: define AFPM_SCHED_TIMEOUT_EN to enable a WAIT-state
// watchdog. After DONE_TMO enabled WAIT cycles without mul_done the scheduler
// answers with a quiet NaN and rsp_err=1. Without the macro WAIT lasts until
// mul_done and rsp_err is constant 0.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : global enable, low freezes all state
//   req_valid[1:0]      : per-requester request
//   req_a/req_b[31:0]   : FP16 operands, requester i in bits [16i+15:16i]
//   req_ready[1:0]      : one-hot acceptance pulse (IDLE only)
//   mul_start           : one-cycle start pulse to the datapath
//   mul_a/mul_b[15:0]   : registered operands for the datapath
//   mul_done, mul_result: datapath completion pulse and product
//   rsp_valid/rsp_id/rsp_data/rsp_err : response, held until rsp_ready
//   rsp_ready           : consumer accepts the response
// -----------------------------------------------------------------------------
module afpm_mul_scheduler
    import afpm_sched_pkg::*;
#(
    parameter int DONE_TMO = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [1:0]  req_ready,
    output logic        mul_start,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    if (DONE_TMO < 1) begin : g_tmo_check
        $error("DONE_TMO must be at least 1");
    end

    sched_state_t      state_reg, state_next;
    logic              ptr_reg, ptr_next;
    logic              id_reg, id_next;
    logic [FP16_W-1:0] mul_a_reg, mul_a_next;
    logic [FP16_W-1:0] mul_b_reg, mul_b_next;
    logic [FP16_W-1:0] rsp_data_reg, rsp_data_next;
    logic [1:0]        grant;

`ifdef AFPM_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(DONE_TMO + 1);
    logic [TMO_W-1:0]  timer_reg, timer_next;
    logic              rsp_err_reg, rsp_err_next;
`endif

    // Unpack the per-requester operand lanes.
    logic [FP16_W-1:0] op_a [NUM_REQ];
    logic [FP16_W-1:0] op_b [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_a[gi] = req_a[gi*FP16_W +: FP16_W];
        assign op_b[gi] = req_b[gi*FP16_W +: FP16_W];
    end

    afpm_rr_arb2 u_arb (
        .valid   (req_valid),
        .pointer (ptr_reg),
        .grant   (grant)
    );

    // Next-state and datapath register updates. With ena low nothing moves.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        id_next       = id_reg;
        mul_a_next    = mul_a_reg;
        mul_b_next    = mul_b_reg;
        rsp_data_next = rsp_data_reg;
`ifdef AFPM_SCHED_TIMEOUT_EN
        timer_next    = timer_reg;
        rsp_err_next  = rsp_err_reg;
`endif
        if (ena) begin
            case (state_reg)
                ST_IDLE: begin
                    if (|grant) begin
                        // grant is one-hot, so bit 1 is the granted index.
                        id_next    = grant[1];
                        ptr_next   = ~grant[1];
                        mul_a_next = op_a[grant[1]];
                        mul_b_next = op_b[grant[1]];
                        state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_next = ST_WAIT;
`ifdef AFPM_SCHED_TIMEOUT_EN
                    timer_next = '0;
`endif
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        rsp_data_next = mul_result;
`ifdef AFPM_SCHED_TIMEOUT_EN
                        rsp_err_next  = 1'b0;
`endif
                        state_next    = ST_RESP;
                    end
`ifdef AFPM_SCHED_TIMEOUT_EN
                    else if (timer_reg == TMO_W'(DONE_TMO - 1)) begin
                        // This is the DONE_TMO-th WAIT cycle with no answer.
                        rsp_data_next = FP16_QNAN;
                        rsp_err_next  = 1'b1;
                        state_next    = ST_RESP;
                    end else begin
                        timer_next = timer_reg + TMO_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= 1'b0;
            id_reg       <= 1'b0;
            mul_a_reg    <= '0;
            mul_b_reg    <= '0;
            rsp_data_reg <= '0;
`ifdef AFPM_SCHED_TIMEOUT_EN
            timer_reg    <= '0;
            rsp_err_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            id_reg       <= id_next;
            mul_a_reg    <= mul_a_next;
            mul_b_reg    <= mul_b_next;
            rsp_data_reg <= rsp_data_next;
`ifdef AFPM_SCHED_TIMEOUT_EN
            timer_reg    <= timer_next;
            rsp_err_reg  <= rsp_err_next;
`endif
        end
    end

    // Handshake strobes come straight from the state so they last exactly
    // as long as the state does, and vanish while ena is low.
    assign req_ready = (ena && (state_reg == ST_IDLE)) ? grant : 2'b00;
    assign mul_start = ena && (state_reg == ST_ISSUE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_id    = id_reg;
    assign rsp_data  = rsp_data_reg;
    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;

`ifdef AFPM_SCHED_TIMEOUT_EN
    assign rsp_err   = rsp_err_reg;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_afpm_mul_scheduler.sv
// -----------------------------------------------------------------------------
// tb_afpm_mul_scheduler
// Directed self-checking bench for afpm_mul_scheduler. Inputs change 1 ns after
// the rising edge, outputs are sampled on the falling edge. The multiplier
// datapath is a stub driven from the scenario tasks.
// Honours AFPM_SCHED_TIMEOUT_EN (timeout scenario vs. no-timeout scenario).
// -----------------------------------------------------------------------------
module tb_afpm_mul_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [1:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_ready;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done;
    logic [15:0] mul_result;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cnt = 0;
    int c_grant, c_start, c_rsp;
    logic [15:0] cap_a, cap_b;

    afpm_mul_scheduler #(.DONE_TMO(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mul_start === 1'b1) start_cnt <= start_cnt + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1, "global timeout");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic grant_cycle(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                               output logic [1:0] gnt);
        req_valid = v; req_a = a; req_b = b;
        @(negedge clk);
        gnt = req_ready;
        c_grant = cyc;
        step();
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mul_start === 1'b1) begin
                cap_a = mul_a; cap_b = mul_b; c_start = cyc;
                step();
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Called at the start of the first WAIT cycle; done arrives dly cycles after start.
    task automatic stub_done(input int dly, input logic [15:0] res);
        repeat (dly - 1) step();
        mul_done = 1'b1; mul_result = res;
        step();
        mul_done = 1'b0;
    endtask

    // Returns on the falling edge of the first RESP cycle.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                c_rsp = cyc; ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] res, input int dly, input bit hold,
                         output bit ok, output logic [1:0] gnt, output logic [15:0] ma,
                         output logic [15:0] mb, output logic id, output logic [15:0] data,
                         output logic err, output int lat, output int nst);
        int s0;
        bit ok1, ok2;
        s0 = start_cnt;
        grant_cycle(v, a, b, gnt);
        if (!hold) req_valid = 2'b00;
        wait_start(ok1);
        ma = cap_a; mb = cap_b;
        stub_done(dly, res);
        wait_rsp(ok2);
        id = rsp_id; data = rsp_data; err = rsp_err; lat = c_rsp - c_grant;
        accept();
        nst = start_cnt - s0;
        ok = ok1 & ok2;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0;
        mul_done = 1'b0; mul_result = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
        checks++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin errors++; $display("FAIL reset_mul_ab: got %h/%h want 0000/0000", mul_a, mul_b); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_id_err: got %b/%b want 0/0", rsp_id, rsp_err); end
        checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
        step();
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single();
        bit ok; logic [1:0] g; logic [15:0] ma, mb, d; logic id, e; int lat, nst;
        do_op(2'b01, 32'h0000_3C00, 32'h0000_4000, 16'h4000, 2, 1'b0, ok, g, ma, mb, id, d, e, lat, nst);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_bound: got %b want 1", ok); end
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", g); end
        checks++; if (nst !== 1) begin errors++; $display("FAIL single_starts: got %0d want 1", nst); end
        checks++; if (ma !== 16'h3C00 || mb !== 16'h4000) begin errors++; $display("FAIL single_operands: got %h/%h want 3c00/4000", ma, mb); end
        checks++; if (id !== 1'b0 || d !== 16'h4000 || e !== 1'b0) begin errors++; $display("FAIL single_rsp: got id=%b data=%h err=%b want 0/4000/0", id, d, e); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d want 4", lat); end
        $display("test_single: grant=%b a=%h b=%h id=%b data=%h lat=%0d", g, ma, mb, id, d, lat);
    endtask

    task automatic test_min_latency();
        bit ok; logic [1:0] g; logic [15:0] ma, mb, d; logic id, e; int lat, nst;
        do_op(2'b10, 32'h4400_FFFF, 32'h3800_0001, 16'h4200, 1, 1'b0, ok, g, ma, mb, id, d, e, lat, nst);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL minlat_bound: got %b want 1", ok); end
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL minlat_grant: got %b want 10", g); end
        checks++; if (ma !== 16'h4400 || mb !== 16'h3800) begin errors++; $display("FAIL minlat_operands: got %h/%h want 4400/3800", ma, mb); end
        checks++; if (id !== 1'b1 || d !== 16'h4200) begin errors++; $display("FAIL minlat_rsp: got id=%b data=%h want 1/4200", id, d); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL minlat_latency: got %0d want 3", lat); end
        $display("test_min_latency: grant=%b id=%b data=%h lat=%0d", g, id, d, lat);
    endtask

    task automatic test_round_robin();
        bit ok; logic [1:0] g, eg; logic [15:0] ma, mb, d, ea, er; logic id, e; int lat, nst;
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            ea = (k % 2 == 0) ? 16'h3C00 : 16'h4400;
            er = 16'h5000 + 16'(k);
            do_op(2'b11, 32'h4400_3C00, 32'h4200_3800, er, 2, 1'b1, ok, g, ma, mb, id, d, e, lat, nst);
            checks++; if (ok !== 1'b1 || g !== eg) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, g, eg); end
            checks++; if (ma !== ea) begin errors++; $display("FAIL rr_mul_a_%0d: got %h want %h", k, ma, ea); end
            checks++; if (id !== eg[1] || d !== er) begin errors++; $display("FAIL rr_rsp_%0d: got id=%b data=%h want %b/%h", k, id, d, eg[1], er); end
            $display("test_round_robin op %0d: grant=%b a=%h id=%b data=%h", k, g, ma, id, d);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_single_vs_pointer();
        bit ok; logic [1:0] g; logic [15:0] ma, mb, d; logic id, e; int lat, nst;
        // Pointer now prefers requester 0, but only requester 1 asks.
        do_op(2'b10, 32'h4600_0000, 32'h3C00_0000, 16'h4600, 2, 1'b0, ok, g, ma, mb, id, d, e, lat, nst);
        checks++; if (ok !== 1'b1 || g !== 2'b10) begin errors++; $display("FAIL lone_grant: got %b want 10", g); end
        checks++; if (id !== 1'b1 || d !== 16'h4600) begin errors++; $display("FAIL lone_rsp: got id=%b data=%h want 1/4600", id, d); end
        $display("test_single_vs_pointer: grant=%b id=%b data=%h", g, id, d);
    endtask

    task automatic test_resp_stall();
        bit ok; logic [1:0] g; logic [15:0] ma, mb, d; logic id, e; int lat, nst;
        grant_cycle(2'b01, 32'h0000_4500, 32'h0000_3C00, g);
        req_valid = 2'b11;
        wait_start(ok);
        stub_done(1, 16'h5555);
        wait_rsp(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_bound: got %b want 1", ok); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL stall_valid_%0d: got %b/%b want 1/0", i, rsp_valid, rsp_id); end
            checks++; if (rsp_data !== 16'h5555) begin errors++; $display("FAIL stall_data_%0d: got %h want 5555", i, rsp_data); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_req_ready_%0d: got %b want 00", i, req_ready); end
            step();
            @(negedge clk);
        end
        req_valid = 2'b00;
        accept();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", rsp_valid); end
        step();
        do_op(2'b01, 32'h0000_3800, 32'h0000_3800, 16'h3400, 1, 1'b0, ok, g, ma, mb, id, d, e, lat, nst);
        checks++; if (ok !== 1'b1 || g !== 2'b01 || d !== 16'h3400) begin errors++; $display("FAIL stall_next_op: got grant=%b data=%h want 01/3400", g, d); end
        $display("test_resp_stall: held 5 cycles, next grant=%b data=%h", g, d);
    endtask

    task automatic test_reset_mid();
        bit ok, seen; logic [1:0] g; logic [15:0] ma, mb, d; logic id, e; int lat, nst;
        grant_cycle(2'b01, 32'h0000_4000, 32'h0000_4000, g);   // pointer moves to 1
        req_valid = 2'b00;
        wait_start(ok);
        step();                                                 // still in WAIT
        rst_n = 1'b0;
        #2;
        checks++; if (mul_a !== 16'h0 || rsp_valid !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL midrst_async: got a=%h v=%b s=%b want 0000/0/0", mul_a, rsp_valid, mul_start); end
        step();
        rst_n = 1'b1;
        mul_done = 1'b1; mul_result = 16'h1234;                 // stale completion
        step();
        mul_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mul_start !== 1'b0) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_stale_done: got activity=%b want 0", seen); end
        checks++; if (rsp_data !== 16'h0 || mul_a !== 16'h0) begin errors++; $display("FAIL midrst_regs: got data=%h a=%h want 0000/0000", rsp_data, mul_a); end
        do_op(2'b11, 32'h4400_3C00, 32'h4200_3800, 16'h4100, 2, 1'b0, ok, g, ma, mb, id, d, e, lat, nst);
        checks++; if (ok !== 1'b1 || g !== 2'b01) begin errors++; $display("FAIL midrst_pointer: got grant=%b want 01", g); end
        $display("test_reset_mid: post-reset grant=%b data=%h", g, d);
    endtask

    task automatic test_ena();
        bit ok; logic [1:0] g; int s0;
        s0 = start_cnt;
        grant_cycle(2'b10, 32'h3C00_0000, 32'h3E00_0000, g);
        req_valid = 2'b00;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mul_start !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL ena_hold_%0d: got start=%b ready=%b want 0/00", i, mul_start, req_ready); end
            step();
        end
        ena = 1'b1;
        @(negedge clk);
        checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL ena_resume_start: got %b want 1", mul_start); end
        step();
        stub_done(2, 16'h3E00);
        wait_rsp(ok);
        checks++; if (ok !== 1'b1 || rsp_data !== 16'h3E00 || rsp_id !== 1'b1) begin errors++; $display("FAIL ena_rsp: got data=%h id=%b want 3e00/1", rsp_data, rsp_id); end
        ena = 1'b0; rsp_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ena_rsp_hold: got %b want 1", rsp_valid); end
        ena = 1'b1;
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ena_rsp_accept: got %b want 0", rsp_valid); end
        step();
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL ena_start_count: got %0d want 1", start_cnt - s0); end
        $display("test_ena: start pulses=%0d", start_cnt - s0);
    endtask

`ifdef AFPM_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; logic [1:0] g; logic [15:0] ma, mb, d; logic id, e; int lat, nst;
        grant_cycle(2'b01, 32'h0000_3C00, 32'h0000_3C00, g);
        req_valid = 2'b00;
        wait_start(ok);
        wait_rsp(ok);
        checks++; if (ok !== 1'b1 || c_rsp - c_start !== 16) begin errors++; $display("FAIL tmo_latency: got %0d want 16", c_rsp - c_start); end
        checks++; if (rsp_data !== 16'h7E00 || rsp_err !== 1'b1) begin errors++; $display("FAIL tmo_rsp: got data=%h err=%b want 7e00/1", rsp_data, rsp_err); end
        $display("test_timeout: data=%h err=%b wait=%0d", rsp_data, rsp_err, c_rsp - c_start);
        accept();
        do_op(2'b01, 32'h0000_3C00, 32'h0000_3C00, 16'h3C00, 2, 1'b0, ok, g, ma, mb, id, d, e, lat, nst);
        checks++; if (ok !== 1'b1 || e !== 1'b0 || d !== 16'h3C00) begin errors++; $display("FAIL tmo_err_clear: got data=%h err=%b want 3c00/0", d, e); end
    endtask
`else
    task automatic test_no_timeout();
        bit ok, seen; logic [1:0] g;
        grant_cycle(2'b01, 32'h0000_3C00, 32'h0000_4400, g);
        req_valid = 2'b00;
        wait_start(ok);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL notmo_wait: got early response=%b want 0", seen); end
        stub_done(1, 16'h4800);
        wait_rsp(ok);
        checks++; if (ok !== 1'b1 || rsp_data !== 16'h4800 || rsp_err !== 1'b0) begin errors++; $display("FAIL notmo_rsp: got data=%h err=%b want 4800/0", rsp_data, rsp_err); end
        $display("test_no_timeout: data=%h err=%b", rsp_data, rsp_err);
        accept();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_min_latency();
        test_round_robin();
        test_single_vs_pointer();
        test_resp_stall();
        test_reset_mid();
        test_ena();
`ifdef AFPM_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
